fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues instruction-memory requests and presents
//  {pc, instr, valid} to decode. It consumes the branch-taken decision (branch_sel) and
//  jump requests from execute, redirects the PC and flushes wrong-path instructions.
//  Maximum one outstanding memory request. A one-entry skid buffer absorbs decode stalls.
// PARAMETERS
//  RESET_PC  32'h0000_0000  First fetch address after reset.
//  NOP_INSTR 32'h0000_0013  Value driven on if_instr when the slot is empty (addi x0,x0,0).
// PORTS
//  clk            in   1   Clock; all state updates on the rising edge.
//  rst            in   1   Asynchronous, active-high reset.
//  stall          in   1   Decode cannot accept; hold the IF/ID output.
//  branch_sel     in   1   Branch taken, from branch control (execute stage).
//  branch_target  in   32  Branch destination PC.
//  jump           in   1   JAL/JALR redirect.
//  jump_target    in   32  Jump destination PC.
//  imem_req       out  1   Fetch request valid.
//  imem_addr      out  32  Fetch address, word aligned.
//  imem_gnt       in   1   Request accepted this cycle (when imem_req=1).
//  imem_rvalid    in   1   Read data valid; in order, one per granted request.
//  imem_rdata     in   32  Instruction word.
//  if_pc          out  32  PC of the presented instruction.
//  if_instr       out  32  Presented instruction.
//  if_valid       out  1   if_pc/if_instr hold a real instruction.
//  flush_id       out  1   Combinational; equals redirect. Decode kills its current entry.
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=BOOT, skid empty, if_valid=0, if_pc=0,
//   if_instr=NOP_INSTR, imem_req=0. flush_id follows its inputs (0 when both are low).
//  redirect = branch_sel|jump. target = jump ? jump_target : branch_target (jump wins).
//   target[1:0] is forced to 2'b00.
//  State machine (imem_req=1 only in REQ; imem_addr=pc, and 0 outside REQ):
//   BOOT  -> REQ unconditionally (one idle cycle after reset release).
//   REQ   gnt: pc<=pc+4 (mod 2^32), ->WAIT. With gnt and redirect together: pc<=target, ->DRAIN.
//         Redirect without gnt: pc<=target, stay in REQ (the new address goes out next cycle).
//   WAIT  rvalid without redirect: accept the response, ->REQ if the skid is empty after
//         this edge, else ->HOLD.
//         Redirect: pc<=target. If rvalid is also high, the response is dropped and the
//         next state is REQ; otherwise ->DRAIN.
//   DRAIN next rvalid is discarded, ->REQ. A further redirect here updates only pc.
//   HOLD  wait for the skid to empty, then ->REQ. A redirect here: pc<=target, ->REQ.
//  Response pc: a register captured at grant, holding the granted address.
//  Output/skid update, evaluated each edge in priority order:
//   1 redirect: if_valid<=0, if_instr<=NOP_INSTR, skid cleared. Overrides stall.
//   2 !stall: skid valid -> output<=skid, skid cleared. Else accepted rvalid -> output<=response.
//     Else if_valid<=0.
//   3 stall and if_valid=0: an accepted rvalid loads the output directly (bubble fill).
//   4 stall and if_valid=1: an accepted rvalid goes to the skid.
//  The skid is never written while full: no request is issued while the skid is valid.
//  Latency: request at cycle N with gnt and rvalid at N+1 -> if_valid=1 at N+2.
//  Reset mid-transaction: all state cleared, outstanding response ignored; the memory
//   is reset by the same rst.
//  Instructions reach decode in program order; none are dropped or duplicated except
//   those flushed by redirect.
// TESTING
//  1 Reset release, imem always gnt, rvalid 1 cycle later -> imem_addr 0,4,8,...;
//    if_pc 0 shows if_valid at cycle 3, then one instruction every 2 cycles.
//  2 stall=1 for 4 cycles while responses arrive -> if_pc held, skid captures the next
//    word, no new req; after stall drops, if_pc advances by exactly 4, nothing lost.
//  3 branch_sel=1, target 0x100, in WAIT with no rvalid -> flush_id=1 that cycle, if_valid=0,
//    the late response is dropped, next imem_addr=0x100.
//  4 jump=1 (0x200) and branch_sel=1 (0x300) together -> next fetch 0x200.
//  5 Redirect in the same cycle as gnt -> DRAIN; the first instruction after the flush has
//    if_pc=target. jump_target 0x203 -> fetch at 0x200.
//  6 PC 0xFFFF_FFFC granted -> next imem_addr 0x0000_0000; rst asserted in WAIT ->
//    outputs at reset values immediately, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. It owns the PC and keeps at most one imem request outstanding.
// A one-entry skid buffer absorbs decode stalls, and a branch or jump redirect flushes wrong-path words.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_sel,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        flush_id
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_HOLD
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_rsp_pc;
  logic        r_skid_valid;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_instr;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;

  logic        w_redirect;
  logic [31:0] w_target_raw;
  logic [31:0] w_target;
  logic        w_grant;
  logic        w_accept;
  logic        w_skid_valid_next;

  assign w_redirect   = branch_sel | jump;
  assign w_target_raw = jump ? jump_target : branch_target;
  assign w_target     = w_target_raw & ALIGN_MASK;
  assign w_grant      = (r_state == S_REQ) && imem_gnt;
  // Only a response that arrives in WAIT and is not killed by a redirect is real.
  assign w_accept     = (r_state == S_WAIT) && imem_rvalid && !w_redirect;

  always_comb begin
    w_skid_valid_next = r_skid_valid;
    if (w_redirect) begin
      w_skid_valid_next = 1'b0;
    end else if (!stall) begin
      w_skid_valid_next = 1'b0;
    end else if (r_if_valid && w_accept) begin
      w_skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_BOOT;
      r_pc     <= RESET_PC & ALIGN_MASK;
      r_rsp_pc <= 32'h0;
    end else begin
      case (r_state)
        S_BOOT: r_state <= S_REQ;
        S_REQ: begin
          if (imem_gnt) begin
            r_rsp_pc <= r_pc;
          end
          if (w_redirect) begin
            r_pc <= w_target;
            if (imem_gnt) begin
              r_state <= S_DRAIN;
            end
          end else if (imem_gnt) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= imem_rvalid ? S_REQ : S_DRAIN;
          end else if (imem_rvalid) begin
            r_state <= w_skid_valid_next ? S_HOLD : S_REQ;
          end
        end
        S_DRAIN: begin
          if (w_redirect) begin
            r_pc <= w_target;
          end
          if (imem_rvalid) begin
            r_state <= S_REQ;
          end
        end
        S_HOLD: begin
          if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= S_REQ;
          end else if (!w_skid_valid_next) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  // The output slot and the skid buffer are updated in priority order: redirect, drain, bubble fill, skid fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_valid   <= 1'b0;
      r_if_pc      <= 32'h0;
      r_if_instr   <= NOP_INSTR;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= 32'h0;
      r_skid_instr <= NOP_INSTR;
    end else if (w_redirect) begin
      r_if_valid   <= 1'b0;
      r_if_instr   <= NOP_INSTR;
      r_skid_valid <= 1'b0;
    end else if (!stall) begin
      if (r_skid_valid) begin
        r_if_valid   <= 1'b1;
        r_if_pc      <= r_skid_pc;
        r_if_instr   <= r_skid_instr;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= r_rsp_pc;
        r_if_instr <= imem_rdata;
      end else begin
        r_if_valid <= 1'b0;
        r_if_instr <= NOP_INSTR;
      end
    end else if (!r_if_valid) begin
      if (w_accept) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= r_rsp_pc;
        r_if_instr <= imem_rdata;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_pc    <= r_rsp_pc;
      r_skid_instr <= imem_rdata;
    end
  end

  assign imem_req  = (r_state == S_REQ);
  assign imem_addr = imem_req ? r_pc : 32'h0;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;
  assign flush_id  = w_redirect;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a table of per-cycle vectors runs against a one-outstanding imem model.
// It is followed by a hand-written reset-in-WAIT sequence.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_sel;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        flush_id;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_sel   (branch_sel),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .if_valid     (if_valid),
    .flush_id     (flush_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        gnt;
    logic        hold;   // withhold a pending response this cycle
    logic        flush;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } row_t;

  row_t        vec[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        pending = 1'b0;
  logic [31:0] pend_addr = 32'h0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic row_t mk(input logic s, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt, input logic g,
                              input logic h, input logic f, input logic rq,
                              input logic [31:0] ad, input logic v, input logic [31:0] p);
    row_t r;
    r.stall = s; r.br = b; r.bt = bt; r.jmp = j; r.jt = jt; r.gnt = g;
    r.hold = h; r.flush = f; r.req = rq; r.addr = ad; r.valid = v; r.pc = p;
    return r;
  endfunction

  // Plain cycle: no stall, no redirect, always grant.
  function automatic row_t pl(input logic rq, input logic [31:0] ad, input logic v,
                              input logic [31:0] p);
    return mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, rq, ad, v, p);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_row(input int idx, input row_t r);
    logic        req_s;
    logic [31:0] addr_s;
    logic        rv_s;
    stall         = r.stall;
    branch_sel    = r.br;
    branch_target = r.bt;
    jump          = r.jmp;
    jump_target   = r.jt;
    imem_gnt      = r.gnt;
    if (pending && !r.hold) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word(pend_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
    chk($sformatf("row%0d flush_id", idx), 32'(flush_id), 32'(r.flush));
    req_s  = imem_req;
    addr_s = imem_addr;
    rv_s   = imem_rvalid;
    @(posedge clk);
    if (rv_s) pending = 1'b0;
    if (req_s && r.gnt) begin
      pending   = 1'b1;
      pend_addr = addr_s;
    end
    @(negedge clk);
    chk($sformatf("row%0d imem_req", idx), 32'(imem_req), 32'(r.req));
    chk($sformatf("row%0d imem_addr", idx), imem_addr, r.addr);
    chk($sformatf("row%0d if_valid", idx), 32'(if_valid), 32'(r.valid));
    if (r.valid) begin
      chk($sformatf("row%0d if_pc", idx), if_pc, r.pc);
      chk($sformatf("row%0d if_instr", idx), if_instr, word(r.pc));
    end
    if (r.flush) chk($sformatf("row%0d if_instr nop", idx), if_instr, NOP);
    $display("row %0d: req=%0b addr=%h valid=%0b pc=%h instr=%h flush=%0b",
             idx, imem_req, imem_addr, if_valid, if_pc, if_instr, flush_id);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " if_valid"}, 32'(if_valid), 32'h0);
    chk({tag, " if_pc"}, if_pc, 32'h0);
    chk({tag, " if_instr"}, if_instr, NOP);
    chk({tag, " imem_req"}, 32'(imem_req), 32'h0);
    chk({tag, " imem_addr"}, imem_addr, 32'h0);
    chk({tag, " flush_id"}, 32'(flush_id), 32'h0);
    $display("%s: valid=%0b pc=%h instr=%h req=%0b", tag, if_valid, if_pc, if_instr, imem_req);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_sel = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = 32'h0;

    // Streaming from reset: one instruction every two cycles
    vec.push_back(pl(1'b1, 32'h0,   1'b0, 32'h0));
    vec.push_back(pl(1'b0, 32'h0,   1'b0, 32'h0));
    vec.push_back(pl(1'b1, 32'h4,   1'b1, 32'h0));
    vec.push_back(pl(1'b0, 32'h0,   1'b0, 32'h0));
    vec.push_back(pl(1'b1, 32'h8,   1'b1, 32'h4));
    vec.push_back(pl(1'b0, 32'h0,   1'b0, 32'h0));
    vec.push_back(pl(1'b1, 32'hC,   1'b1, 32'h8));
    // Four stall cycles: the skid buffer catches word 0xC and no request goes out
    for (int i = 0; i < 4; i++)
      vec.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8));
    vec.push_back(pl(1'b1, 32'h10,  1'b1, 32'hC));
    vec.push_back(pl(1'b0, 32'h0,   1'b0, 32'h0));
    vec.push_back(pl(1'b1, 32'h14,  1'b1, 32'h10));
    vec.push_back(pl(1'b0, 32'h0,   1'b0, 32'h0));
    // Branch in WAIT before the response: the late word 0x14 is dropped
    vec.push_back(mk(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0));
    vec.push_back(pl(1'b1, 32'h100, 1'b0, 32'h0));
    vec.push_back(pl(1'b0, 32'h0,   1'b0, 32'h0));
    vec.push_back(pl(1'b1, 32'h104, 1'b1, 32'h100));
    // Jump and branch together in REQ without grant: jump wins
    vec.push_back(mk(1'b0, 1'b1, 32'h300, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0));
    vec.push_back(pl(1'b0, 32'h0,   1'b0, 32'h0));
    vec.push_back(pl(1'b1, 32'h204, 1'b1, 32'h200));
    // Jump to an unaligned target together with a grant: DRAIN, then refetch at 0x200
    vec.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h203, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0));
    vec.push_back(pl(1'b1, 32'h200, 1'b0, 32'h0));
    vec.push_back(pl(1'b0, 32'h0,   1'b0, 32'h0));
    vec.push_back(pl(1'b1, 32'h204, 1'b1, 32'h200));
    vec.push_back(pl(1'b0, 32'h0,   1'b0, 32'h0));
    // Branch in WAIT in the same cycle as rvalid: the word is dropped and REQ comes next
    vec.push_back(mk(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0));
    vec.push_back(pl(1'b0, 32'h0,   1'b0, 32'h0));
    vec.push_back(pl(1'b1, 32'h44,  1'b1, 32'h40));
    vec.push_back(pl(1'b0, 32'h0,   1'b0, 32'h0));
    // Bubble fill: stalled with an empty slot, the response still loads the output
    vec.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h48, 1'b1, 32'h44));
    vec.push_back(pl(1'b0, 32'h0,   1'b0, 32'h0));
    vec.push_back(pl(1'b1, 32'h4C,  1'b1, 32'h48));
    // Wrap around from 0xFFFF_FFFC to 0
    vec.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0));
    vec.push_back(pl(1'b0, 32'h0,   1'b0, 32'h0));
    vec.push_back(pl(1'b1, 32'h0,   1'b1, 32'hFFFF_FFFC));
    vec.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    foreach (vec[i]) run_row(i, vec[i]);

    // Reset asserted in WAIT with a valid output and a response outstanding
    rst = 1'b1;
    stall = 1'b0;
    imem_rvalid = 1'b0;
    pending = 1'b0;
    #1;
    chk_reset("midreset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_row(100, pl(1'b1, 32'h0, 1'b0, 32'h0));
    run_row(101, pl(1'b0, 32'h0, 1'b0, 32'h0));
    run_row(102, pl(1'b1, 32'h4, 1'b1, 32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
